// File: rtl/sch_issue_queue.sv
// Collapsing, age-ordered issue queue feeding the scheduling register.
// Entries stay contiguous from index 0 (oldest); the oldest fully-ready entry is presented.
module sch_issue_queue #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32,
  parameter int CTL_W  = 4,
  parameter int PT_W   = 96
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CTL_W-1:0]         in_alu_ctl,
  input  logic                     in_op1_rdy,
  input  logic                     in_op2_rdy,
  input  logic [TAG_W-1:0]         in_op1_tag,
  input  logic [TAG_W-1:0]         in_op2_tag,
  input  logic [DATA_W-1:0]        in_op1_val,
  input  logic [DATA_W-1:0]        in_op2_val,
  input  logic [PT_W-1:0]          in_pt,
  input  logic                     wb_valid,
  input  logic [TAG_W-1:0]         wb_tag,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     stall,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [CTL_W-1:0]         out_alu_ctl,
  output logic [DATA_W-1:0]        out_op1,
  output logic [DATA_W-1:0]        out_op2,
  output logic [PT_W-1:0]          out_pt,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic [CTL_W-1:0]  ctl;
    logic              rdy1;
    logic [TAG_W-1:0]  tag1;
    logic [DATA_W-1:0] val1;
    logic              rdy2;
    logic [TAG_W-1:0]  tag2;
    logic [DATA_W-1:0] val2;
    logic [PT_W-1:0]   pt;
  } entry_t;

  entry_t            ent_r     [DEPTH];
  entry_t            ent_nx_s  [DEPTH];
  entry_t            new_raw_s;
  entry_t            new_s;
  entry_t            sel_ent_s;
  entry_t            moved_s;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_nx_s;
  logic [CNT_W-1:0]  wr_pos_s;
  logic [DEPTH-1:0]  issuable_s;
  logic [DEPTH-1:0]  shift_s;
  logic [IDX_W-1:0]  sel_idx_s;
  logic              sel_found_s;
  logic              issue_s;
  logic              dispatch_s;

  // Capture a matching broadcast into any operand still waiting on it.
  function automatic entry_t wake(input entry_t e, input logic wv,
                                  input logic [TAG_W-1:0] wt, input logic [DATA_W-1:0] wd);
    entry_t r;
    logic   w1;
    logic   w2;
    r  = e;
    w1 = wv && !e.rdy1 && (e.tag1 == wt);
    w2 = wv && !e.rdy2 && (e.tag2 == wt);
    r.rdy1 = e.rdy1 | w1;
    r.val1 = w1 ? wd : e.val1;
    r.rdy2 = e.rdy2 | w2;
    r.val2 = w2 ? wd : e.val2;
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] first_set(input logic [DEPTH-1:0] v);
    logic [IDX_W-1:0] r;
    r = {IDX_W{1'b0}};
    for (int i = DEPTH - 1; i >= 0; i--) begin
      r = v[IDX_W'(i)] ? IDX_W'(i) : r;
    end
    return r;
  endfunction

  assign in_ready   = (count_r < CNT_W'(DEPTH)) && !flush;
  assign dispatch_s = in_valid && in_ready;
  assign issue_s    = sel_found_s && !stall && !flush;
  assign wr_pos_s   = count_r - CNT_W'(issue_s);
  assign count      = count_r;

  // Oldest-first selection among valid entries with both operands ready.
  always_comb begin
    issuable_s = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      issuable_s[IDX_W'(i)] = (CNT_W'(i) < count_r) && ent_r[IDX_W'(i)].rdy1 && ent_r[IDX_W'(i)].rdy2;
    end
    sel_found_s = |issuable_s;
    sel_idx_s   = first_set(issuable_s);
    sel_ent_s   = ent_r[sel_idx_s];
  end

  assign out_valid   = sel_found_s;
  assign out_alu_ctl = sel_found_s ? sel_ent_s.ctl  : {CTL_W{1'b0}};
  assign out_op1     = sel_found_s ? sel_ent_s.val1 : {DATA_W{1'b0}};
  assign out_op2     = sel_found_s ? sel_ent_s.val2 : {DATA_W{1'b0}};
  assign out_pt      = sel_found_s ? sel_ent_s.pt   : {PT_W{1'b0}};

  // Next-state: collapse above the issued slot, apply wakeup, append the new entry after the collapse.
  always_comb begin
    new_raw_s.ctl  = in_alu_ctl;
    new_raw_s.rdy1 = in_op1_rdy;
    new_raw_s.tag1 = in_op1_tag;
    new_raw_s.val1 = in_op1_val;
    new_raw_s.rdy2 = in_op2_rdy;
    new_raw_s.tag2 = in_op2_tag;
    new_raw_s.val2 = in_op2_val;
    new_raw_s.pt   = in_pt;
    new_s          = wake(new_raw_s, wb_valid, wb_tag, wb_data);
    shift_s        = {DEPTH{1'b0}};
    moved_s        = {$bits(entry_t){1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      shift_s[IDX_W'(i)] = issue_s && (IDX_W'(i) >= sel_idx_s);
      moved_s = shift_s[IDX_W'(i)] ? ent_r[IDX_W'((i < DEPTH - 1) ? i + 1 : i)] : ent_r[IDX_W'(i)];
      moved_s = wake(moved_s, wb_valid, wb_tag, wb_data);
      ent_nx_s[IDX_W'(i)] = (dispatch_s && (CNT_W'(i) == wr_pos_s)) ? new_s : moved_s;
    end
    count_nx_s = flush ? {CNT_W{1'b0}} : (count_r + CNT_W'(dispatch_s) - CNT_W'(issue_s));
  end

  // Entry storage and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        ent_r[IDX_W'(i)] <= {$bits(entry_t){1'b0}};
      end
    end else begin
      count_r <= count_nx_s;
      for (int i = 0; i < DEPTH; i++) begin
        ent_r[IDX_W'(i)] <= ent_nx_s[IDX_W'(i)];
      end
    end
  end

endmodule
